usr_sequencer: RTL
==================

// Module: usr_sequencer
// PURPOSE
//  Command sequencer for the 4-bit universal shift register (hold / shift-right / shift-left / parallel-load).
//  Accepts one command per valid/ready handshake, then drives the register's mode, serial and parallel inputs cycle by cycle.
//  Supports LOAD, CLEAR, logical shifts and rotates by N positions, and signals completion with a one-cycle done pulse.
//  Sits between the host/control logic and the shift register; register output Q is fed back via q_in.
// PARAMETERS
//  WIDTH  4  register width (sr_d, q_in, cmd_data)
//  CNT_W  3  shift-count width; counts 0..2^CNT_W-1
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command (== state IDLE)
//  cmd_op     in   3      000 NOP,001 LOAD,010 SHR,011 SHL,100 ROTR,101 ROTL,110 CLEAR,111 rsvd(=NOP)
//  cmd_cnt    in   CNT_W  shift/rotate distance (ignored by LOAD/CLEAR/NOP)
//  cmd_data   in   WIDTH  parallel value for LOAD
//  cmd_fill   in   1      serial fill bit for SHR/SHL
//  q_in       in   WIDTH  current register Q (registered feedback)
//  sr_ena     out  1      register enable
//  sr_mode    out  2      {S1,S0}: 00 hold,01 shift right,10 shift left,11 load
//  sr_sl      out  1      serial-left input (enters Q[0] on shift left)
//  sr_sr      out  1      serial-right input (enters Q[WIDTH-1] on shift right)
//  sr_d       out  WIDTH  parallel load data
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: command completed
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, cmd_ready=1, sr_ena=0, sr_mode=00, sr_sl=0, sr_sr=0, sr_d=0, busy=0, done=0,
//    latched op/cnt/data/fill=0, remaining-count=0. Inputs ignored while rst=1.
//  - States: IDLE, LOAD, SHIFT, DONE. Outside LOAD/SHIFT: sr_ena=0, sr_mode=00.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready edge latch op, cnt, data, fill, then:
//    LOAD/CLEAR -> LOAD; SHR/SHL/ROTR/ROTL with cnt!=0 -> SHIFT (remaining=cnt); cnt==0, NOP, 111 -> DONE.
//  - LOAD (1 cycle): sr_ena=1, sr_mode=11, sr_d=data (CLEAR: 0). -> DONE.
//  - SHIFT: sr_ena=1; SHR/ROTR mode=01, SHL/ROTL mode=10. Serial bits:
//    SHR sr_sr=fill, SHL sr_sl=fill, ROTR sr_sr=q_in[0], ROTL sr_sl=q_in[WIDTH-1]; unused serial bit=0.
//    Each cycle remaining decrements; after exactly cnt enable cycles -> DONE. cnt>WIDTH allowed
//    (rotate wraps modulo WIDTH; logical shift fills entirely with fill).
//  - DONE (1 cycle): done=1, cmd_ready=0 -> IDLE.
//  - Latency: accept at edge k; register updated at edges k+1..k+n (n=1 for LOAD/CLEAR, cnt for shifts);
//    done high in cycle after last update; next accept no earlier than edge k+n+2. Zero-op: done in cycle after k.
//  - sr_d driven to latched data only in LOAD; 0 otherwise. All outputs registered or decoded from state only
//    (serial bits additionally from q_in, combinational).
//  - cmd_valid while busy: not accepted, nothing latched; command inputs may change freely.
//  - Reset mid-command: command abandoned, no done pulse; register Q left at whatever value it reached.
// TESTING (bench includes behavioural model of 4-bit register fed by sr_* outputs, q_in from model)
//  1 Reset release, LOAD data=1011 -> exactly one cycle sr_mode=11,sr_d=1011; Q=1011; done 1 cycle; busy 2 cycles.
//  2 From 1011, ROTL cnt=5 -> 5 cycles mode=10, sr_sl=q_in[3]; Q=0111; done once; cmd_ready back next cycle.
//  3 From 0111, SHR cnt=2 fill=1 -> Q 1011 then 1101; sr_sl=0 throughout; done once.
//  4 SHL cnt=0, and op=111 -> sr_ena never asserted, Q unchanged, done in cycle after accept.
//  5 cmd_valid held high across two queued commands (LOAD 0101, ROTR 1) -> each accepted once, Q=1010, two done pulses.
//  6 rst asserted in 3rd cycle of SHL cnt=6 -> outputs idle immediately, no done; after release CLEAR -> Q=0000, done.

Source files
------------

// File: rtl/usr_sequencer.sv
// usr_sequencer
//   Command sequencer for a universal shift register (hold / shift right /
//   shift left / parallel load). It accepts one command per valid/ready
//   handshake and then drives the register's control inputs cycle by cycle:
//   LOAD, CLEAR, logical shifts and rotates by N positions. A one-cycle
//   done pulse marks the end of every accepted command.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  command can be accepted (sequencer idle)
//   cmd_op     000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROTR, 101 ROTL,
//              110 CLEAR, 111 reserved (treated as NOP)
//   cmd_cnt    shift/rotate distance
//   cmd_data   parallel value for LOAD
//   cmd_fill   serial fill bit for SHR/SHL
//   q_in       current register Q (feedback for rotates)
//   sr_ena     register enable
//   sr_mode    {S1,S0}: 00 hold, 01 shift right, 10 shift left, 11 load
//   sr_sl      serial-left input (enters Q[0] on shift left)
//   sr_sr      serial-right input (enters Q[WIDTH-1] on shift right)
//   sr_d       parallel load data
//   busy       sequencer not idle
//   done       one-cycle completion pulse
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_in,
    output logic             sr_ena,
    output logic [1:0]       sr_mode,
    output logic             sr_sl,
    output logic             sr_sr,
    output logic [WIDTH-1:0] sr_d,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROTR  = 3'b100;
    localparam logic [2:0] OP_ROTL  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    state_t             state;
    state_t             state_next;
    logic [2:0]         op;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   data;
    logic               fill;
    logic [CNT_W-1:0]   remaining;
    logic               accept;

    assign accept = cmd_valid && (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= '0;
            cnt       <= '0;
            data      <= '0;
            fill      <= 1'b0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op        <= cmd_op;
                cnt       <= cmd_cnt;
                data      <= cmd_data;
                fill      <= cmd_fill;
                remaining <= cmd_cnt;
            end else if (state == S_SHIFT) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    // Next-state decode. Shifts with a zero count, NOP and the reserved
    // opcode go straight to DONE so the host still sees a completion pulse.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD, OP_CLEAR: state_next = S_LOAD;
                        OP_SHR, OP_SHL, OP_ROTR, OP_ROTL:
                            state_next = (cmd_cnt != '0) ? S_SHIFT : S_DONE;
                        default: state_next = S_DONE;
                    endcase
                end
            end
            S_LOAD:  state_next = S_DONE;
            S_SHIFT: if (remaining == CNT_W'(1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode from state and latched command. Rotates take the bit
    // falling off the far end straight from q_in, so the register sees its
    // own current value recirculated on every enabled edge.
    always_comb begin
        sr_ena  = 1'b0;
        sr_mode = 2'b00;
        sr_sl   = 1'b0;
        sr_sr   = 1'b0;
        sr_d    = '0;
        case (state)
            S_LOAD: begin
                sr_ena  = 1'b1;
                sr_mode = 2'b11;
                sr_d    = (op == OP_LOAD) ? data : '0;
            end
            S_SHIFT: begin
                sr_ena = 1'b1;
                case (op)
                    OP_SHR: begin
                        sr_mode = 2'b01;
                        sr_sr   = fill;
                    end
                    OP_SHL: begin
                        sr_mode = 2'b10;
                        sr_sl   = fill;
                    end
                    OP_ROTR: begin
                        sr_mode = 2'b01;
                        sr_sr   = q_in[0];
                    end
                    OP_ROTL: begin
                        sr_mode = 2'b10;
                        sr_sl   = q_in[WIDTH-1];
                    end
                    default: sr_mode = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // cnt is kept with the latched command for observability; the
    // countdown runs on remaining.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule
